// File: rtl/nrisc_pkg.sv
// Shared encodings for the nRISC fetch/PC unit and its return stack.
package nrisc_pkg;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } pc_op_e;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Frame tag sits above the return address; a set tag marks an interrupt frame.
    localparam int unsigned TAG_W = 1;

endpackage

// File: rtl/nrisc_ret_stack.sv
// LIFO return-address stack; contents survive reset, only the occupancy clears.
module nrisc_ret_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[PTR_W'(count - CNT_W'(1))];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PTR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/nrisc_pc_stack_unit.sv
// Fetch/PC sequencer with call/return stack, vectored interrupts and a one-bubble redirect.
module nrisc_pc_stack_unit
    import nrisc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned VEC_BASE    = 'h3F0,
    parameter int unsigned VEC_STRIDE  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic [INSTR_W-1:0]             imem_data,
    output logic [INSTR_W-1:0]             instr_out,
    output logic                           instr_valid,
    output logic [ADDR_W-1:0]              exec_pc,
    input  logic [1:0]                     pc_op,
    input  logic [ADDR_W-1:0]              target,
    input  logic                           stall,
    input  logic [NUM_IRQ-1:0]             irq_req,
    output logic                           irq_ack,
    output logic [$clog2(NUM_IRQ)-1:0]     irq_id,
    output logic                           in_isr,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           stack_ovf,
    output logic                           stack_unf
);

    localparam int unsigned ID_W    = $clog2(NUM_IRQ);
    localparam int unsigned FRAME_W = ADDR_W + TAG_W;

    state_e               state, state_nxt;
    logic [ADDR_W-1:0]    pc, pc_nxt, exec_pc_nxt, vec_addr;
    logic                 in_isr_nxt, ovf_nxt, unf_nxt, ack_nxt;
    logic [ID_W-1:0]      id_nxt, irq_n;
    logic                 irq_any;
    logic                 push, pop, full, empty;
    logic [FRAME_W-1:0]   push_frame, pop_frame;
    logic [INSTR_W-1:0]   hold;
    logic                 stalled_q;

    nrisc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (FRAME_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_frame),
        .dout  (pop_frame),
        .full  (full),
        .empty (empty),
        .count (sp)
    );

    assign imem_addr = pc;

    // Memory output moves on during a stall, so the stalled word is replayed from hold.
    assign instr_out = instr_valid ? (stalled_q ? hold : imem_data) : '0;

    // Lowest-index pending request wins.
    always_comb begin
        irq_any = |irq_req;
        irq_n   = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                irq_n = ID_W'(i);
            end
        end
        vec_addr = ADDR_W'(VEC_BASE + 32'(irq_n) * VEC_STRIDE);
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        exec_pc_nxt = exec_pc;
        in_isr_nxt  = in_isr;
        ovf_nxt     = stack_ovf;
        unf_nxt     = stack_unf;
        ack_nxt     = 1'b0;
        id_nxt      = irq_id;
        push        = 1'b0;
        pop         = 1'b0;
        push_frame  = {TAG_W'(0), exec_pc + ADDR_W'(1)};
        if (!stall) begin
            unique case (state)
                ST_FILL, ST_FLUSH: begin
                    state_nxt   = ST_RUN;
                    pc_nxt      = pc + ADDR_W'(1);
                    exec_pc_nxt = pc;
                end
                ST_RUN: begin
                    unique case (pc_op)
                        OP_SEQ: begin
                            if (irq_any && !in_isr) begin
                                push       = !full;
                                ovf_nxt    = stack_ovf | full;
                                push_frame = {TAG_W'(1), exec_pc + ADDR_W'(1)};
                                pc_nxt     = vec_addr;
                                ack_nxt    = 1'b1;
                                id_nxt     = irq_n;
                                in_isr_nxt = 1'b1;
                                state_nxt  = ST_FLUSH;
                            end else begin
                                pc_nxt      = pc + ADDR_W'(1);
                                exec_pc_nxt = pc;
                            end
                        end
                        OP_JUMP: begin
                            pc_nxt    = target;
                            state_nxt = ST_FLUSH;
                        end
                        OP_CALL: begin
                            push      = !full;
                            ovf_nxt   = stack_ovf | full;
                            pc_nxt    = target;
                            state_nxt = ST_FLUSH;
                        end
                        OP_RET: begin
                            if (empty) begin
                                unf_nxt = 1'b1;
                                pc_nxt  = pc + ADDR_W'(1);
                            end else begin
                                pop    = 1'b1;
                                pc_nxt = pop_frame[ADDR_W-1:0];
                                if (pop_frame[FRAME_W-1 -: TAG_W] != '0) begin
                                    in_isr_nxt = 1'b0;
                                end
                            end
                            state_nxt = ST_FLUSH;
                        end
                    endcase
                end
                default: state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= ADDR_W'(RESET_PC);
            exec_pc     <= '0;
            in_isr      <= 1'b0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
            irq_ack     <= 1'b0;
            irq_id      <= '0;
            instr_valid <= 1'b0;
            hold        <= '0;
            stalled_q   <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            exec_pc     <= exec_pc_nxt;
            in_isr      <= in_isr_nxt;
            stack_ovf   <= ovf_nxt;
            stack_unf   <= unf_nxt;
            irq_ack     <= ack_nxt;
            irq_id      <= id_nxt;
            instr_valid <= (state_nxt == ST_RUN);
            hold        <= instr_out;
            stalled_q   <= stall;
        end
    end

endmodule

// File: tb/tb_nrisc_pc_stack_unit.sv
// Directed bench for nrisc_pc_stack_unit with a per-cycle fetch/execute scoreboard.
module tb_nrisc_pc_stack_unit;
    import nrisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [9:0]  exec_pc;
    logic [1:0]  pc_op;
    logic [9:0]  target;
    logic        stall;
    logic [7:0]  irq_req;
    logic        irq_ack;
    logic [2:0]  irq_id;
    logic        in_isr;
    logic [4:0]  sp;
    logic        stack_ovf;
    logic        stack_unf;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       valid;
        logic [9:0] pc;
    } obs_t;

    obs_t       exp_q[$];
    logic [9:0] rs[$];
    logic [9:0] cur;
    logic [9:0] t;

    nrisc_pc_stack_unit #(
        .ADDR_W      (10),
        .INSTR_W     (16),
        .STACK_DEPTH (16),
        .NUM_IRQ     (8),
        .RESET_PC    ('h010),
        .VEC_BASE    ('h3F0),
        .VEC_STRIDE  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .exec_pc     (exec_pc),
        .pc_op       (pc_op),
        .target      (target),
        .stall       (stall),
        .irq_req     (irq_req),
        .irq_ack     (irq_ack),
        .irq_id      (irq_id),
        .in_isr      (in_isr),
        .sp          (sp),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] instr_at(input logic [9:0] a);
        return {6'h2A, a};
    endfunction

    // One-cycle synchronous instruction ROM.
    always @(posedge clk) imem_data <= instr_at(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_obs(input logic v, input logic [9:0] a);
        exp_q.push_back(obs_t'{v, a});
        if (v) cur = a;
    endtask

    task automatic tick(input logic [1:0] op, input logic [9:0] tgt);
        obs_t e;
        pc_op  = op;
        target = tgt;
        @(posedge clk);
        #2;
        pc_op  = 2'b00;
        target = '0;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_underrun: observed empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            check("instr_valid", 32'(instr_valid), 32'(e.valid));
            if (e.valid) begin
                check("exec_pc", 32'(exec_pc), 32'(e.pc));
                check("instr_out", 32'(instr_out), 32'(instr_at(e.pc)));
            end else begin
                check("nop_out", 32'(instr_out), 0);
            end
        end
    endtask

    task automatic step_seq();
        expect_obs(1'b1, cur + 10'd1);
        tick(OP_SEQ, '0);
    endtask

    task automatic ctrl(input logic [1:0] op, input logic [9:0] tgt);
        expect_obs(1'b0, '0);
        tick(op, tgt);
    endtask

    task automatic land(input logic [9:0] dest);
        expect_obs(1'b1, dest);
        tick(OP_SEQ, '0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; pc_op = 2'b00; target = '0; irq_req = '0;
        cur = '0; t = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_imem_addr", 32'(imem_addr), 'h010);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_exec_pc", 32'(exec_pc), 0);
        check("rst_sp", 32'(sp), 0);
        check("rst_in_isr", 32'(in_isr), 0);
        check("rst_ovf", 32'(stack_ovf), 0);
        check("rst_unf", 32'(stack_unf), 0);
        check("rst_irq_ack", 32'(irq_ack), 0);
        check("rst_irq_id", 32'(irq_id), 0);
        check("rst_instr_out", 32'(instr_out), 0);
        rst = 1'b1;
        land(10'h010);

        // call / return
        step_seq();
        step_seq();
        ctrl(OP_CALL, 10'h200);
        check("call_sp", 32'(sp), 1);
        land(10'h200);
        check("call_sp_run", 32'(sp), 1);
        step_seq();
        ctrl(OP_RET, '0);
        check("ret_sp", 32'(sp), 0);
        land(10'h013);

        // PC wrap
        ctrl(OP_JUMP, 10'h3FE);
        land(10'h3FE);
        step_seq();
        step_seq();

        // interrupt with a second channel held pending
        ctrl(OP_JUMP, 10'h04F);
        land(10'h04F);
        step_seq();
        irq_req = 8'b0010_0100;
        ctrl(OP_SEQ, '0);
        check("irq2_ack", 32'(irq_ack), 1);
        check("irq2_id", 32'(irq_id), 2);
        check("irq2_in_isr", 32'(in_isr), 1);
        check("irq2_sp", 32'(sp), 1);
        land(10'h3F4);
        check("irq2_ack_pulse", 32'(irq_ack), 0);
        irq_req = 8'b0010_0000;
        step_seq();
        check("irq5_masked_a", 32'(irq_ack), 0);
        step_seq();
        check("irq5_masked_b", 32'(irq_ack), 0);
        check("isr_held", 32'(in_isr), 1);
        ctrl(OP_RET, '0);
        check("reti_in_isr", 32'(in_isr), 0);
        check("reti_sp", 32'(sp), 0);
        land(10'h051);
        ctrl(OP_SEQ, '0);
        check("irq5_ack", 32'(irq_ack), 1);
        check("irq5_id", 32'(irq_id), 5);
        check("irq5_in_isr", 32'(in_isr), 1);
        land(10'h3FA);
        irq_req = '0;
        ctrl(OP_RET, '0);
        land(10'h052);
        check("reti5_in_isr", 32'(in_isr), 0);

        // jump beats a coincident irq; stall frozen in FLUSH
        irq_req = 8'b0000_0001;
        ctrl(OP_JUMP, 10'h100);
        check("jmp_irq_ack", 32'(irq_ack), 0);
        stall = 1'b1;
        repeat (3) begin
            expect_obs(1'b0, '0);
            tick(OP_CALL, 10'h155);
            check("stall_addr", 32'(imem_addr), 'h100);
            check("stall_ack", 32'(irq_ack), 0);
            check("stall_sp", 32'(sp), 0);
        end
        stall = 1'b0;
        land(10'h100);
        check("deferred_ack_pre", 32'(irq_ack), 0);
        ctrl(OP_SEQ, '0);
        check("deferred_ack", 32'(irq_ack), 1);
        check("deferred_id", 32'(irq_id), 0);
        land(10'h3F0);
        irq_req = '0;
        ctrl(OP_RET, '0);
        land(10'h101);

        // stall while running holds the executing instruction
        stall = 1'b1;
        irq_req = 8'h80;
        repeat (2) begin
            expect_obs(1'b1, 10'h101);
            tick(OP_JUMP, 10'h2AA);
            check("run_stall_ack", 32'(irq_ack), 0);
            check("run_stall_addr", 32'(imem_addr), 'h102);
        end
        stall = 1'b0;
        irq_req = '0;
        step_seq();

        // reset mid-FLUSH, with stall also high
        ctrl(OP_CALL, 10'h300);
        check("pre_rst_sp", 32'(sp), 1);
        rst = 1'b0;
        stall = 1'b1;
        @(posedge clk);
        #2;
        check("rst2_imem_addr", 32'(imem_addr), 'h010);
        check("rst2_valid", 32'(instr_valid), 0);
        check("rst2_sp", 32'(sp), 0);
        check("rst2_exec_pc", 32'(exec_pc), 0);
        rst = 1'b1;
        stall = 1'b0;
        land(10'h010);
        step_seq();

        // overflow then underflow
        for (int i = 0; i < 17; i++) begin
            t = 10'h200 + 10'(4 * i);
            if (rs.size() < 16) rs.push_back(cur + 10'd1);
            ctrl(OP_CALL, t);
            land(t);
            if (i == 15) check("ovf_before_full", 32'(stack_ovf), 0);
        end
        check("ovf_sp", 32'(sp), 16);
        check("ovf_flag", 32'(stack_ovf), 1);
        for (int i = 0; i < 16; i++) begin
            ctrl(OP_RET, '0);
            land(rs.pop_back());
        end
        check("unf_before", 32'(stack_unf), 0);
        check("unf_sp_empty", 32'(sp), 0);
        ctrl(OP_RET, '0);
        check("unf_flag", 32'(stack_unf), 1);
        check("unf_sp", 32'(sp), 0);
        @(posedge clk);
        #2;
        check("unf_resume_valid", 32'(instr_valid), 1);
        check("unf_sticky", 32'(stack_unf), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nrisc_pc_stack_unit.md
NRISC_PC_STACK_UNIT -- requirements
Module: nrisc_pc_stack_unit

Interface
REQ-001 SHALL have parameters: ADDR_W, default 10, PC/address width; INSTR_W, default 16, instruction width; STACK_DEPTH, default 16, return-stack entries (power of 2, >=2); NUM_IRQ, default 8, interrupt channels; RESET_PC, default 0, fetch address after reset; VEC_BASE, default 0x3F0, vector table base; VEC_STRIDE, default 2, address step per vector.
REQ-002 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_addr  out  ADDR_W  fetch address, equal to PC register.
- imem_data  in  INSTR_W  instruction memory read data, one-cycle synchronous read.
- instr_out  out  INSTR_W  instruction to core; all-zero (NOP) when instr_valid=0.
- instr_valid  out  1  instr_out is executable.
- exec_pc  out  ADDR_W  address of the instruction on instr_out.
- pc_op  in  2  00 sequential, 01 jump, 10 call, 11 return; sampled only when instr_valid=1.
- target  in  ADDR_W  jump/call destination.
- stall  in  1  freeze all state.
- irq_req  in  NUM_IRQ  level interrupt requests.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- irq_id  out  $clog2(NUM_IRQ)  channel taken, valid with irq_ack.
- in_isr  out  1  handler active; further interrupts masked.
- sp  out  $clog2(STACK_DEPTH)+1  current stack occupancy.
- stack_ovf  out  1  sticky push-on-full.
- stack_unf  out  1  sticky pop-on-empty.

Function
REQ-003 SHALL use FSM states FILL (first fetch outstanding), RUN, FLUSH (redirected fetch outstanding); instr_valid=1 only in RUN.
REQ-004 SHALL, in RUN with stall=0 and pc_op=00 and no interrupt taken, advance PC to PC+1 (modulo 2^ADDR_W) and update exec_pc to the previous PC.
REQ-005 SHALL, on pc_op=01, load PC with target and enter FLUSH for exactly one cycle.
REQ-006 SHALL, on pc_op=10, push exec_pc+1, load PC with target, and enter FLUSH.
REQ-007 SHALL, on pc_op=11, pop the top entry into PC and enter FLUSH; if the popped frame was an interrupt frame, in_isr SHALL clear.
REQ-008 SHALL take an interrupt in RUN when stall=0, pc_op=00, in_isr=0, and any irq_req bit is set.
REQ-009 SHALL select the lowest-index asserted channel n when taking an interrupt.
REQ-010 SHALL, on taking an interrupt, push exec_pc+1 tagged as an interrupt frame, load PC with VEC_BASE+n*VEC_STRIDE, pulse irq_ack with irq_id=n, set in_isr, and enter FLUSH.
REQ-011 SHALL give a non-zero pc_op priority over an interrupt in the same cycle; the interrupt is deferred to the next eligible RUN cycle.
REQ-012 SHALL, on a call at sp=STACK_DEPTH, still take the jump, drop the push, keep sp unchanged, and set stack_ovf.
REQ-013 SHALL, on a return at sp=0, set stack_unf, advance PC sequentially, and enter FLUSH.
REQ-014 SHALL, while stall=1, hold PC, exec_pc, sp, FSM state, instr_out and instr_valid, and ignore pc_op and irq_req.
REQ-015 SHALL keep irq_ack low while stall=1.
REQ-016 SHALL apply no arithmetic saturation; the PC wraps from 2^ADDR_W-1 to 0.
REQ-017 SHALL make the redirect latency one bubble cycle: the first target instruction appears with instr_valid=1 two clocks after the control op is sampled.

Reset
REQ-018 SHALL, on rst=0 at a clock edge, set PC=RESET_PC, exec_pc=0, sp=0, state=FILL, in_isr=0, stack_ovf=0, stack_unf=0, irq_ack=0, irq_id=0, instr_valid=0, instr_out=0.
REQ-019 SHALL give reset priority over stall, pc_op and interrupts.
REQ-020 SHALL not clear stack contents on reset; only sp is cleared.
REQ-021 SHALL, on reset mid-FLUSH, discard the pending redirect.
REQ-022 SHALL present the RESET_PC instruction with instr_valid=1 in the second cycle after rst deasserts.

Structure
REQ-023 SHALL place the pc_op encodings, the FSM state encoding and the frame-tag width in the shared nrisc_pkg package.
REQ-024 SHALL implement the return stack as sub-module nrisc_ret_stack: push/pop/full/empty, ADDR_W+1-bit entries (address + interrupt tag), depth STACK_DEPTH.
REQ-025 SHALL implement the priority encoder inline.

Verification
REQ-026 SHALL cover: reset with RESET_PC=0x010 -> imem_addr=0x010; instr_valid rises the second cycle after release; exec_pc=0x010.
REQ-027 SHALL cover: call target=0x200 at exec_pc=0x012 -> one NOP bubble, exec_pc=0x200, sp=1; subsequent return -> exec_pc=0x013, sp=0.
REQ-028 SHALL cover: irq_req=8'b0010_0100 in a sequential cycle at exec_pc=0x050 -> irq_ack pulse with irq_id=2, exec_pc=0x3F4, in_isr=1; irq 5 stays masked until return, then returns to 0x051 and services irq 5.
REQ-029 SHALL cover: 17 calls with STACK_DEPTH=16 -> stack_ovf=1 and sp=16; 17 returns -> stack_unf=1 on the last.
REQ-030 SHALL cover: a jump coincident with an irq -> jump taken, irq_ack delayed to the first RUN cycle after FLUSH; stall=1 for 3 cycles mid-FLUSH -> all outputs frozen, then resume unchanged.
